// File: rtl/sr_drv_pkg.sv
// Shared types and counter widths for the S/R flip-flop driver.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int HOLD_W  = 4;
  localparam int RETRY_W = 3;

endpackage

// File: rtl/sr_ff_driver.sv
// Drives S/R excitation to move an external flop to a requested value, confirms via Q feedback,
// retries up to MAX_RETRY times and then parks in a sticky error until err_clr.
module sr_ff_driver
  import sr_drv_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int MAX_RETRY   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_q,
  output logic req_ready,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic done,
  output logic err,
  input  logic err_clr
);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t              state;
  logic                tgt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [RETRY_W-1:0]  retry_cnt;

  assign req_ready = (state == IDLE);

  // s and r are only ever loaded as tgt/~tgt or both zero, so they cannot overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt       <= 1'b0;
      hold_cnt  <= '0;
      retry_cnt <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            tgt       <= req_q;
            retry_cnt <= '0;
            hold_cnt  <= '0;
            if (q_fb == req_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRIVE;
              s     <= req_q;
              r     <= ~req_q;
            end
          end
        end
        DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= CHECK;
            hold_cnt <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        CHECK: begin
          if (q_fb == tgt) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
            state     <= DRIVE;
            s         <= tgt;
            r         <= ~tgt;
          end else begin
            state <= ERROR;
            err   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERROR: begin
          if (err_clr) begin
            state <= IDLE;
            err   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          s     <= 1'b0;
          r     <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
